// File: rtl/gate_bist_controller.sv
// Built-in self-test controller for the AND/OR/NOT gate unit: applies ab = 00..11,
// waits SETTLE_CYCLES per vector, checks x/y/z and records per-vector/per-gate failures.
module gate_bist_controller #(
    parameter int unsigned SETTLE_CYCLES = 1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic       x_in,
    input  logic       y_in,
    input  logic       z_in,
    output logic       a_out,
    output logic       b_out,
    output logic       busy,
    output logic       done,
    output logic       pass,
    output logic [3:0] err_vec,
    output logic [2:0] fail_gate,
    output logic [2:0] fail_count
);

    typedef enum logic [1:0] {
        IDLE,
        SETTLE,
        CHECK,
        FINISH
    } state_t;

    localparam logic [3:0] SETTLE_LAST = 4'(SETTLE_CYCLES - 1);

    state_t     state_q, state_d;
    logic [1:0] vec_q, vec_d;
    logic [3:0] settle_q, settle_d;
    logic       a_q, a_d;
    logic       b_q, b_d;
    logic       busy_q, busy_d;
    logic       done_q, done_d;
    logic       pass_q, pass_d;
    logic [3:0] err_vec_q, err_vec_d;
    logic [2:0] fail_gate_q, fail_gate_d;
    logic [2:0] fail_count_q, fail_count_d;

    logic       start_run;
    logic [2:0] mismatch;

    assign start_run = start && (state_q == IDLE || state_q == FINISH);

    // Per-gate mismatch against the truth table of the currently applied vector: {z, y, x}
    assign mismatch = {z_in ^ ~a_q, y_in ^ (a_q | b_q), x_in ^ (a_q & b_q)};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= IDLE;
            vec_q        <= '0;
            settle_q     <= '0;
            a_q          <= 1'b0;
            b_q          <= 1'b0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            pass_q       <= 1'b0;
            err_vec_q    <= '0;
            fail_gate_q  <= '0;
            fail_count_q <= '0;
        end else begin
            state_q      <= state_d;
            vec_q        <= vec_d;
            settle_q     <= settle_d;
            a_q          <= a_d;
            b_q          <= b_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
            pass_q       <= pass_d;
            err_vec_q    <= err_vec_d;
            fail_gate_q  <= fail_gate_d;
            fail_count_q <= fail_count_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE, FINISH: begin
                if (start_run) state_d = SETTLE;
            end
            SETTLE: begin
                if (settle_q == SETTLE_LAST) state_d = CHECK;
            end
            CHECK: begin
                state_d = (vec_q == 2'd3) ? FINISH : SETTLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        vec_d        = vec_q;
        settle_d     = settle_q;
        a_d          = a_q;
        b_d          = b_q;
        busy_d       = busy_q;
        done_d       = done_q;
        pass_d       = pass_q;
        err_vec_d    = err_vec_q;
        fail_gate_d  = fail_gate_q;
        fail_count_d = fail_count_q;
        case (state_q)
            IDLE, FINISH: begin
                if (start_run) begin
                    vec_d        = '0;
                    settle_d     = '0;
                    a_d          = 1'b0;
                    b_d          = 1'b0;
                    busy_d       = 1'b1;
                    done_d       = 1'b0;
                    pass_d       = 1'b0;
                    err_vec_d    = '0;
                    fail_gate_d  = '0;
                    fail_count_d = '0;
                end
            end
            SETTLE: begin
                settle_d = settle_q + 4'd1;
            end
            CHECK: begin
                if (|mismatch) begin
                    err_vec_d    = err_vec_q | (4'b0001 << vec_q);
                    fail_gate_d  = fail_gate_q | mismatch;
                    fail_count_d = fail_count_q + 3'd1;
                end
                if (vec_q != 2'd3) begin
                    vec_d        = vec_q + 2'd1;
                    {a_d, b_d}   = vec_q + 2'd1;
                    settle_d     = '0;
                end else begin
                    busy_d = 1'b0;
                    done_d = 1'b1;
                    // pass must reflect the update made by this final check
                    pass_d = (fail_count_q == 3'd0) && !(|mismatch);
                end
            end
            default: ;
        endcase
    end

    assign a_out      = a_q;
    assign b_out      = b_q;
    assign busy       = busy_q;
    assign done       = done_q;
    assign pass       = pass_q;
    assign err_vec    = err_vec_q;
    assign fail_gate  = fail_gate_q;
    assign fail_count = fail_count_q;

endmodule

// File: tb/tb_gate_bist_controller.sv
// Self-checking bench: two controllers (SETTLE_CYCLES 1 and 3) each drive a gate-unit
// model whose outputs are corrupted by a per-vector fault mask.
module tb_gate_bist_controller;

    logic             clk = 1'b0;
    logic             rst;
    logic [1:0]       start;
    logic [1:0][11:0] mask;

    logic [1:0]       a_o, b_o, busy_o, done_o, pass_o;
    logic [1:0]       x_i, y_i, z_i;
    logic [1:0][3:0]  ev_o;
    logic [1:0][2:0]  fg_o, fc_o;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    // Gate unit model: correct {z,y,x} for vector {a,b}, flipped by that vector's mask bits
    function automatic logic [2:0] gate_out(input logic a, input logic b, input logic [11:0] m);
        int k;
        k = {30'd0, a, b};
        return {~a, a | b, a & b} ^ m[3*k +: 3];
    endfunction

    assign {z_i[0], y_i[0], x_i[0]} = gate_out(a_o[0], b_o[0], mask[0]);
    assign {z_i[1], y_i[1], x_i[1]} = gate_out(a_o[1], b_o[1], mask[1]);

    gate_bist_controller #(.SETTLE_CYCLES(1)) dut1 (
        .clk(clk), .rst(rst), .start(start[0]),
        .x_in(x_i[0]), .y_in(y_i[0]), .z_in(z_i[0]),
        .a_out(a_o[0]), .b_out(b_o[0]), .busy(busy_o[0]), .done(done_o[0]), .pass(pass_o[0]),
        .err_vec(ev_o[0]), .fail_gate(fg_o[0]), .fail_count(fc_o[0])
    );

    gate_bist_controller #(.SETTLE_CYCLES(3)) dut3 (
        .clk(clk), .rst(rst), .start(start[1]),
        .x_in(x_i[1]), .y_in(y_i[1]), .z_in(z_i[1]),
        .a_out(a_o[1]), .b_out(b_o[1]), .busy(busy_o[1]), .done(done_o[1]), .pass(pass_o[1]),
        .err_vec(ev_o[1]), .fail_gate(fg_o[1]), .fail_count(fc_o[1])
    );

    typedef struct {
        string       name;
        int          sel;
        logic [11:0] m;
        logic [3:0]  ev;
        logic [2:0]  fg;
        logic [2:0]  fc;
        logic        p;
    } rec_t;

    localparam int NREC = 6;
    rec_t tbl[NREC];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Expected results from the fault mask: a vector fails if any of its gates is corrupted
    task automatic model(input logic [11:0] m, output logic [3:0] ev, output logic [2:0] fg,
                         output logic [2:0] fc, output logic p);
        int n;
        ev = '0;
        fg = '0;
        n  = 0;
        for (int k = 0; k < 4; k++) begin
            if (m[3*k +: 3] != 3'b000) begin
                ev[k] = 1'b1;
                n++;
            end
            fg |= m[3*k +: 3];
        end
        fc = 3'(n);
        p  = (n == 0);
    endtask

    task automatic check_all_zero(input string name, input int sel);
        check({name, " a_out"}, a_o[sel], 0);
        check({name, " b_out"}, b_o[sel], 0);
        check({name, " busy"}, busy_o[sel], 0);
        check({name, " done"}, done_o[sel], 0);
        check({name, " pass"}, pass_o[sel], 0);
        check({name, " err_vec"}, ev_o[sel], 0);
        check({name, " fail_gate"}, fg_o[sel], 0);
        check({name, " fail_count"}, fc_o[sel], 0);
    endtask

    // One full run with a one-cycle start pulse; optionally a second pulse at cycle restart_at+1
    task automatic run(input string name, input int sel, input logic [11:0] m,
                       input logic [3:0] ev, input logic [2:0] fg, input logic [2:0] fc,
                       input logic p, input int restart_at);
        int   hold;
        logic ok;
        hold = (sel == 0) ? 2 : 4;
        mask[sel] = m;
        @(negedge clk);
        start[sel] = 1'b1;
        @(negedge clk);
        start[sel] = 1'b0;
        ok = 1'b1;
        for (int k = 0; k < 4 * hold; k++) begin
            if (k == restart_at) start[sel] = 1'b1;
            else start[sel] = 1'b0;
            if (busy_o[sel] !== 1'b1 || done_o[sel] !== 1'b0 ||
                {a_o[sel], b_o[sel]} !== 2'(k / hold)) ok = 1'b0;
            if (k == 0 && (ev_o[sel] !== 4'd0 || fg_o[sel] !== 3'd0 ||
                           fc_o[sel] !== 3'd0 || pass_o[sel] !== 1'b0)) ok = 1'b0;
            @(negedge clk);
        end
        start[sel] = 1'b0;
        check({name, " sequence"}, ok, 1);
        check({name, " done"}, done_o[sel], 1);
        check({name, " busy"}, busy_o[sel], 0);
        check({name, " pass"}, pass_o[sel], p);
        check({name, " err_vec"}, ev_o[sel], ev);
        check({name, " fail_gate"}, fg_o[sel], fg);
        check({name, " fail_count"}, fc_o[sel], fc);
    endtask

    initial begin
        logic [11:0] m;
        logic [3:0]  ev;
        logic [2:0]  fg, fc;
        logic        p;
        int          sel;

        tbl[0] = '{"good_s1",      0, 12'h000, 4'b0000, 3'b000, 3'd0, 1'b1};
        tbl[1] = '{"y_stuck0_s1",  0, 12'h490, 4'b1110, 3'b010, 3'd3, 1'b0};
        tbl[2] = '{"restart_good", 0, 12'h000, 4'b0000, 3'b000, 3'd0, 1'b1};
        tbl[3] = '{"z_eq_a_s1",    0, 12'h924, 4'b1111, 3'b100, 3'd4, 1'b0};
        tbl[4] = '{"good_s3",      1, 12'h000, 4'b0000, 3'b000, 3'd0, 1'b1};
        tbl[5] = '{"x_fault00_s3", 1, 12'h001, 4'b0001, 3'b001, 3'd1, 1'b0};

        rst   = 1'b1;
        start = '0;
        mask  = '0;
        #1;
        check_all_zero("reset_s1", 0);
        check_all_zero("reset_s3", 1);
        repeat (2) @(negedge clk);
        rst = 1'b0;

        for (int i = 0; i < NREC; i++)
            run(tbl[i].name, tbl[i].sel, tbl[i].m, tbl[i].ev, tbl[i].fg, tbl[i].fc, tbl[i].p, -1);

        // Second start pulse sampled mid-run must not restart or disturb the run
        run("start_while_busy", 0, 12'h000, 4'b0000, 3'b000, 3'd0, 1'b1, 2);

        // start held high: done lasts one cycle, then an immediate restart
        mask[0] = 12'h000;
        @(negedge clk);
        start[0] = 1'b1;
        repeat (9) @(negedge clk);
        check("held_start first done", done_o[0], 1);
        @(negedge clk);
        start[0] = 1'b0;
        check("held_start done drops", done_o[0], 0);
        check("held_start busy again", busy_o[0], 1);
        check("held_start vector 00", {a_o[0], b_o[0]}, 0);
        repeat (8) @(negedge clk);
        check("held_start second done", done_o[0], 1);
        check("held_start second pass", pass_o[0], 1);

        // Asynchronous reset while vector 10 is applied
        mask[0] = 12'h490;
        @(negedge clk);
        start[0] = 1'b1;
        @(negedge clk);
        start[0] = 1'b0;
        repeat (4) @(negedge clk);
        check("midrun vector", {a_o[0], b_o[0]}, 2'b10);
        check("midrun err_vec", ev_o[0], 4'b0010);
        #2 rst = 1'b1;
        #1;
        check_all_zero("midrun_reset", 0);
        @(negedge clk);
        rst = 1'b0;
        repeat (3) @(negedge clk);
        check("after_reset done", done_o[0], 0);
        check("after_reset busy", busy_o[0], 0);

        for (int i = 0; i < 24; i++) begin
            sel = int'($urandom_range(0, 1));
            m   = ($urandom_range(0, 3) == 0) ? 12'h000 : 12'($urandom);
            model(m, ev, fg, fc, p);
            run($sformatf("random%0d_m%03h", i, m), sel, m, ev, fg, fc, p, -1);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/gate_bist_controller.md
Name: gate_bist_controller

Overview:
- Built-in self-test controller that drives the two inputs of the basic AND/OR/NOT gate unit and checks its three outputs.
- It applies all four input vectors in order (ab = 00, 01, 10, 11), waits a settle time for each, then compares each response with the expected truth table.
- It reports pass/fail plus a per-vector and per-gate failure record.
- It sits beside the gate unit as the initiator: its stimulus outputs connect to the gate unit's a/b, and the gate unit's x/y/z feed back into it.

Parameters:
- SETTLE_CYCLES, 1, number of cycles each vector is held before its response is sampled; legal range 1..15.

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  asynchronous, active-high reset
- start  input  1  begins a test run; sampled in IDLE or FINISH only
- x_in  input  1  AND output from the gate unit under test
- y_in  input  1  OR output from the gate unit under test
- z_in  input  1  NOT output from the gate unit under test
- a_out  output  1  stimulus a to the gate unit (registered)
- b_out  output  1  stimulus b to the gate unit (registered)
- busy  output  1  high while a run is in progress
- done  output  1  high from run completion until the next start or reset
- pass  output  1  valid while done=1; 1 if no mismatch occurred
- err_vec  output  4  bit k set if vector k (k = {a,b}) mismatched on any gate
- fail_gate  output  3  sticky per-gate mismatch flags; bit0 = x, bit1 = y, bit2 = z
- fail_count  output  3  number of failing vectors, 0..4

Behaviour:
- Reset (asynchronous, any time, including mid-run): state=IDLE; a_out, b_out, busy, done, pass = 0; err_vec, fail_gate, fail_count = 0; vector and settle counters = 0. Reset takes effect immediately, with no clock required.
- States: IDLE, SETTLE, CHECK, FINISH.
- IDLE, or FINISH, with start=1 at an edge:
  - a_out/b_out <= 00; vector counter <= 0; settle counter <= 0.
  - err_vec, fail_gate, fail_count, done, pass cleared.
  - busy <= 1; go to SETTLE.
- SETTLE:
  - Hold a_out/b_out; increment the settle counter each cycle.
  - When the counter reaches SETTLE_CYCLES-1, go to CHECK at the next edge.
- CHECK (exactly one cycle):
  - At the closing edge, compare x_in with a_out&b_out, y_in with a_out|b_out, z_in with ~a_out.
  - On any mismatch: set err_vec[vector], OR the per-gate mismatch bits into fail_gate, increment fail_count.
  - If vector < 3: vector+1, drive the new {a_out,b_out}, clear the settle counter, go to SETTLE.
  - If vector = 3: go to FINISH.
- FINISH:
  - busy=0, done=1.
  - pass=1 iff the final fail_count=0, including any update made by the last CHECK.
  - All result outputs hold until start or reset.
- Latency: done rises 4*(SETTLE_CYCLES+1) cycles after the edge that sampled start (8 cycles for the default).
- Inputs x_in/y_in/z_in are sampled only at CHECK edges; glitches at any other time are ignored.
- start while busy=1 is ignored, with no restart and no effect on results.
- start held high continuously: one run, then an immediate restart from FINISH on the first FINISH cycle. done is high for exactly one cycle in that case.
- Vector order is fixed at 00, 01, 10, 11. Bit k of err_vec maps to {a,b}=k, so vector 10 is a=1, b=0.
- fail_count saturates naturally at 4 (maximum of one increment per vector); it never wraps.
- All outputs are registered; no combinational path from inputs to outputs.

Test Plan:
- Correct gate model, SETTLE_CYCLES=1, pulse start for one cycle -> a_out/b_out step through 00, 01, 10, 11, each held 2 cycles; done=1 after 8 cycles; pass=1, err_vec=0000, fail_gate=000, fail_count=0.
- Gate model with y stuck-at-0 -> done after 8 cycles; pass=0, err_vec=1110, fail_gate=010, fail_count=3.
- Gate model with z=a instead of ~a -> err_vec=1111, fail_gate=100, fail_count=4, pass=0.
- SETTLE_CYCLES=3, correct model -> each vector held 4 cycles; done after 16 cycles; pass=1.
- Reset scenario:
  - Correct model, start pulse, then start pulsed again at cycle 3 -> second pulse ignored; single run completes at cycle 8.
  - Then assert rst mid-run while vector 10 is applied -> a_out, b_out, busy immediately 0; done stays 0; all result outputs 0.
- Restart from FINISH: failing run (err_vec=1110), then start with a correct model -> results clear on the start edge; second run ends with pass=1, err_vec=0000.
